// File: rtl/mux_pkg.sv
// Shared types for the 2:1 mux select arbiter.
// State encoding and channel indices.
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } arb_state_t;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

endpackage

// File: rtl/mux_sel_arbiter_hold_counter.sv
// Saturating hold counter for the arbiter grant burst.
// Clear wins over count; tc flags the saturation value.
module hold_counter #(
  parameter int W     = 3,
  parameter int LIMIT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] TOP = W'(LIMIT);

  logic [W-1:0] cnt;

  assign tc = (cnt == TOP);

  // count cycles of the current grant, stopping at TOP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the 2:1 bit mux select.
// Bursts are capped at MAX_HOLD cycles under contention.
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic       sel,
  output logic [1:0] grant,
  output logic       busy
);

  import mux_pkg::*;

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam int CNT_W = (CW > 1) ? CW : 1;

  arb_state_t state;
  arb_state_t nxt;
  logic       last;
  logic       tc;
  logic       stay;

  // next grant: tie from idle goes to the channel not served last
  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        unique case (1'b1)
          req == 2'b00: nxt = IDLE;
          req == 2'b01: nxt = G0;
          req == 2'b10: nxt = G1;
          default:      nxt = (last == CH0) ? G1 : G0;
        endcase
      end
      G0: begin
        if (!req[0] || (tc && req[1])) begin
          nxt = req[1] ? G1 : IDLE;
        end
      end
      G1: begin
        if (!req[1] || (tc && req[0])) begin
          nxt = req[0] ? G0 : IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  assign stay = (nxt == state) && (state != IDLE);

  hold_counter #(
    .W     (CNT_W),
    .LIMIT (MAX_HOLD - 1)
  ) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!stay),
    .en    (stay),
    .tc    (tc)
  );

  // state register with outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= 2'b00;
      busy  <= 1'b0;
      sel   <= CH0;
      last  <= CH1;
    end else begin
      state <= nxt;
      grant <= {nxt == G1, nxt == G0};
      busy  <= (nxt != IDLE);
      if (nxt == G0) begin
        sel  <= CH0;
        last <= CH0;
      end else if (nxt == G1) begin
        sel  <= CH1;
        last <= CH1;
      end
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: directed table plus
// model-driven scoreboard on MAX_HOLD=4 and =1 builds.
module tb_mux_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic       sel4, sel1, busy4, busy1;
  logic [1:0] grant4, grant1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         rst_n;
    logic [1:0] req;
    logic [1:0] g;
    logic       s;
  } vec_t;

  typedef struct {
    logic [1:0] g;
    logic       s;
    logic       b;
  } exp_t;

  vec_t tbl[$];
  exp_t q4[$];
  exp_t q1[$];

  int m_st[2];
  int m_cnt[2];
  bit m_last[2];
  bit m_sel[2];
  int m_mh[2] = '{4, 1};

  mux_sel_arbiter #(.MAX_HOLD(4)) u4 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .sel   (sel4),
    .grant (grant4),
    .busy  (busy4)
  );

  mux_sel_arbiter #(.MAX_HOLD(1)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .sel   (sel1),
    .grant (grant1),
    .busy  (busy1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: sim did not end, limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic m_enter(int i, int c);
    m_st[i]   = c + 1;
    m_cnt[i]  = 0;
    m_last[i] = (c == 1);
    m_sel[i]  = (c == 1);
  endtask

  task automatic model(int i, bit rn, logic [1:0] r,
                       output exp_t e);
    int n;
    int o;
    if (!rn) begin
      m_st[i] = 0; m_cnt[i] = 0;
      m_last[i] = 1'b1; m_sel[i] = 1'b0;
    end else if (m_st[i] == 0) begin
      if (r == 2'b01) m_enter(i, 0);
      else if (r == 2'b10) m_enter(i, 1);
      else if (r == 2'b11) m_enter(i, m_last[i] ? 0 : 1);
    end else begin
      n = m_st[i] - 1;
      o = 1 - n;
      if (!r[n] || (m_cnt[i] == m_mh[i] - 1 && r[o])) begin
        if (r[o]) m_enter(i, o);
        else begin
          m_st[i] = 0; m_cnt[i] = 0;
        end
      end else if (m_cnt[i] < m_mh[i] - 1) begin
        m_cnt[i]++;
      end
    end
    e.g = (m_st[i] == 1) ? 2'b01 :
          (m_st[i] == 2) ? 2'b10 : 2'b00;
    e.s = m_sel[i];
    e.b = (m_st[i] != 0);
  endtask

  task automatic inv(string nm, logic [1:0] g,
                     logic s, logic b);
    chk({nm, "_no11"}, {3'b0, g == 2'b11}, 4'h0);
    chk({nm, "_busy"}, {3'b0, b}, {3'b0, |g});
    if (b) chk({nm, "_sel"}, {3'b0, s}, {3'b0, g[1]});
  endtask

  task automatic step(bit rn, logic [1:0] r, bit use_t,
                      logic [1:0] tg, logic ts, string nm);
    exp_t e4, e1, a;
    @(negedge clk);
    rst_n = rn;
    req   = r;
    model(0, rn, r, e4);
    model(1, rn, r, e1);
    if (use_t) e4 = '{tg, ts, |tg};
    q4.push_back(e4);
    q1.push_back(e1);
    @(posedge clk);
    #1;
    if (q4.size() == 0 || q1.size() == 0) begin
      chk("sb_empty", 4'h1, 4'h0);
    end else begin
      a = q4.pop_front();
      chk({nm, "_h4"}, {1'b0, grant4, sel4}, {1'b0, a.g, a.s});
      chk({nm, "_h4b"}, {3'b0, busy4}, {3'b0, a.b});
      a = q1.pop_front();
      chk({nm, "_h1"}, {1'b0, grant1, sel1}, {1'b0, a.g, a.s});
      chk({nm, "_h1b"}, {3'b0, busy1}, {3'b0, a.b});
    end
    inv("inv4", grant4, sel4, busy4);
    inv("inv1", grant1, sel1, busy1);
  endtask

  task automatic add(bit rn, logic [1:0] r,
                     logic [1:0] g, logic s);
    vec_t v;
    v.rst_n = rn; v.req = r; v.g = g; v.s = s;
    tbl.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 2'b00;
    // reset held with both requesting
    for (int k = 0; k < 3; k++) add(0, 2'b11, 2'b00, 0);
    // release into a contested run: 4-cycle bursts
    for (int k = 0; k < 20; k++) begin
      if ((k / 4) % 2 == 1) add(1, 2'b11, 2'b10, 1);
      else add(1, 2'b11, 2'b01, 0);
    end
    add(1, 2'b00, 2'b00, 0);
    // lone requester on channel 1, sel held when idle
    for (int k = 0; k < 10; k++) add(1, 2'b10, 2'b10, 1);
    add(1, 2'b00, 2'b00, 1);
    add(1, 2'b00, 2'b00, 1);
    // early release at hold count 1
    add(1, 2'b11, 2'b01, 0);
    add(1, 2'b11, 2'b01, 0);
    add(1, 2'b10, 2'b10, 1);
    add(1, 2'b00, 2'b00, 1);
    add(1, 2'b11, 2'b01, 0);
    // swap on simultaneous drop and rise
    add(1, 2'b10, 2'b10, 1);
    add(1, 2'b01, 2'b01, 0);
    // reset while channel 1 holds at count 2
    add(1, 2'b10, 2'b10, 1);
    add(1, 2'b10, 2'b10, 1);
    add(1, 2'b10, 2'b10, 1);
    add(0, 2'b10, 2'b00, 0);
    add(1, 2'b11, 2'b01, 0);
    // uncontested hold saturates, then expires at once
    for (int k = 0; k < 8; k++) add(1, 2'b01, 2'b01, 0);
    add(1, 2'b11, 2'b10, 1);
    add(1, 2'b00, 2'b00, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst_n, tbl[i].req, 1'b1,
           tbl[i].g, tbl[i].s, "vec");
    end

    for (int k = 0; k < 10000; k++) begin
      step($urandom_range(63) != 0,
           2'($urandom_range(3)), 1'b0, 2'b00, 1'b0, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
